// File: rtl/regfile_pkg.sv
// Shared definitions for the X/Y register-file sequencer: opcode map, state
// encoding, instruction field positions and the opcode classifier.
package regfile_pkg;

  localparam int unsigned IW          = 16;
  localparam int unsigned OPCODE_W    = 6;
  localparam int unsigned REG_SEL_BIT = 9;
  localparam int unsigned CNT_W       = 4;

  localparam logic [OPCODE_W-1:0] OP_NOP    = 6'h00;
  localparam logic [OPCODE_W-1:0] OP_LDI    = 6'h01;
  localparam logic [OPCODE_W-1:0] OP_LD     = 6'h02;
  localparam logic [OPCODE_W-1:0] OP_ST     = 6'h03;
  localparam logic [OPCODE_W-1:0] OP_ALU_LO = 6'h04;
  localparam logic [OPCODE_W-1:0] OP_ALU_HI = 6'h0F;

  typedef enum logic [2:0] {
    IDLE, DECODE, RDREG, MEM, ALU, WB
  } state_e;

  typedef enum logic [2:0] {
    CL_NOP, CL_LDI, CL_LD, CL_ST, CL_ALU, CL_ILL
  } op_class_e;

  // Collapse the opcode space into the handful of behaviours the sequencer knows.
  function automatic op_class_e classify(input logic [OPCODE_W-1:0] op);
    op_class_e cls;
    cls = CL_ILL;
    if (op == OP_NOP)                         cls = CL_NOP;
    else if (op == OP_LDI)                    cls = CL_LDI;
    else if (op == OP_LD)                     cls = CL_LD;
    else if (op == OP_ST)                     cls = CL_ST;
    else if (op >= OP_ALU_LO && op <= OP_ALU_HI) cls = CL_ALU;
    return cls;
  endfunction

endpackage

// File: rtl/regfile_ctrl_tmo.sv
// Wait-cycle watchdog shared by the MEM and ALU states: loaded on entry,
// decremented each waiting cycle, flags the last permitted cycle.
module regfile_ctrl_tmo
  import regfile_pkg::*;
#(
  parameter int unsigned TMO = 15
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic clear,
  input  logic en,
  output logic expired
);

  logic [CNT_W-1:0] count;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                      count <= '0;
    else if (start)                count <= CNT_W'(TMO);
    else if (clear)                count <= '0;
    else if (en && count != '0)    count <= count - CNT_W'(1);
  end

  // A count of one marks the final wait cycle; an ack in that cycle still wins.
  assign expired = (count == CNT_W'(1));

endmodule

// File: rtl/regfile_ctrl.sv
// Multicycle sequencer for the two-entry register file: accepts one instruction,
// drives rw and the one-hot write strobes, and handshakes with memory and the ALU.
module regfile_ctrl
  import regfile_pkg::*;
#(
  parameter int unsigned OPW = 6,
  parameter int unsigned TMO = 15
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          instr_valid,
  output logic          instr_ready,
  input  logic [IW-1:0] instr,
  output logic          mem_req,
  output logic          mem_we,
  input  logic          mem_ack,
  output logic          alu_start,
  input  logic          alu_done,
  output logic          rw,
  output logic          lse,
  output logic          ldm,
  output logic          lacc,
  output logic          busy,
  output logic          err
);

  state_e          state;
  logic [IW-1:0]   ir;
  op_class_e       cls;
  logic            tmo_start;
  logic            tmo_clear;
  logic            tmo_en;
  logic            expired;
  logic            unused_operand;

  assign cls = classify(OPCODE_W'(ir[IW-1 -: OPW]));
  // Operand bits feed sign-extend/address logic elsewhere, not this block.
  assign unused_operand = ^ir[REG_SEL_BIT-1:0];

  assign tmo_start = ((state == DECODE) && (cls == CL_LD || cls == CL_ALU)) ||
                     (state == RDREG);
  assign tmo_clear = ((state == MEM) && mem_ack) || ((state == ALU) && alu_done);
  assign tmo_en    = (state == MEM) || (state == ALU);

  regfile_ctrl_tmo #(.TMO(TMO)) u_tmo (
    .clk     (clk),
    .rst     (rst),
    .start   (tmo_start),
    .clear   (tmo_clear),
    .en      (tmo_en),
    .expired (expired)
  );

  // State and every output update together so all outputs come straight from flops.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      ir          <= '0;
      instr_ready <= 1'b0;
      rw          <= 1'b0;
      lse         <= 1'b0;
      ldm         <= 1'b0;
      lacc        <= 1'b0;
      mem_req     <= 1'b0;
      mem_we      <= 1'b0;
      alu_start   <= 1'b0;
      busy        <= 1'b0;
      err         <= 1'b0;
    end else begin
      lse       <= 1'b0;
      ldm       <= 1'b0;
      lacc      <= 1'b0;
      alu_start <= 1'b0;
      err       <= 1'b0;
      case (state)
        IDLE: begin
          instr_ready <= 1'b1;
          if (instr_valid && instr_ready) begin
            ir          <= instr;
            state       <= DECODE;
            instr_ready <= 1'b0;
            busy        <= 1'b1;
          end
        end
        DECODE: begin
          rw <= ir[REG_SEL_BIT];
          case (cls)
            CL_LDI: begin
              state <= WB;
              lse   <= 1'b1;
            end
            CL_LD: begin
              state   <= MEM;
              mem_req <= 1'b1;
              mem_we  <= 1'b0;
            end
            CL_ST:  state <= RDREG;
            CL_ALU: begin
              state     <= ALU;
              alu_start <= 1'b1;
            end
            default: begin
              state       <= IDLE;
              busy        <= 1'b0;
              instr_ready <= 1'b1;
              rw          <= 1'b0;
              err         <= (cls == CL_ILL);
            end
          endcase
        end
        // One cycle for the file output to settle on the new rw before the store.
        RDREG: begin
          state   <= MEM;
          mem_req <= 1'b1;
          mem_we  <= 1'b1;
        end
        MEM: begin
          if (mem_ack) begin
            mem_req <= 1'b0;
            mem_we  <= 1'b0;
            if (cls == CL_LD) begin
              state <= WB;
              ldm   <= 1'b1;
            end else begin
              state       <= IDLE;
              busy        <= 1'b0;
              instr_ready <= 1'b1;
              rw          <= 1'b0;
            end
          end else if (expired) begin
            mem_req     <= 1'b0;
            mem_we      <= 1'b0;
            err         <= 1'b1;
            state       <= IDLE;
            busy        <= 1'b0;
            instr_ready <= 1'b1;
            rw          <= 1'b0;
          end
        end
        ALU: begin
          if (alu_done) begin
            state <= WB;
            lacc  <= 1'b1;
          end else if (expired) begin
            err         <= 1'b1;
            state       <= IDLE;
            busy        <= 1'b0;
            instr_ready <= 1'b1;
            rw          <= 1'b0;
          end
        end
        default: begin
          state       <= IDLE;
          busy        <= 1'b0;
          instr_ready <= 1'b1;
          rw          <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_regfile_ctrl.sv
// Directed bench for regfile_ctrl: per-cycle output traces after each accept,
// checked against hand-derived cycle positions.
module tb_regfile_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        instr_valid;
  logic        instr_ready;
  logic [15:0] instr;
  logic        mem_req, mem_we, mem_ack;
  logic        alu_start, alu_done;
  logic        rw, lse, ldm, lacc, busy, err;

  int total = 0;
  int bad   = 0;

  localparam int B_LSE = 0, B_LDM = 1, B_LACC = 2, B_REQ = 3, B_WE = 4;
  localparam int B_AST = 5, B_RW = 6, B_RDY = 7, B_BUSY = 8, B_ERR = 9;
  localparam int TN = 40;

  logic [9:0] tr [0:TN-1];

  regfile_ctrl dut (
    .clk         (clk),
    .rst         (rst),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .instr       (instr),
    .mem_req     (mem_req),
    .mem_we      (mem_we),
    .mem_ack     (mem_ack),
    .alu_start   (alu_start),
    .alu_done    (alu_done),
    .rw          (rw),
    .lse         (lse),
    .ldm         (ldm),
    .lacc        (lacc),
    .busy        (busy),
    .err         (err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [9:0] snap();
    return {err, busy, instr_ready, rw, alu_start, mem_we, mem_req, lacc, ldm, lse};
  endfunction

  // Runs n cycles recording outputs; valid held while k < vld_until, acks driven in the given cycle.
  task automatic run(input int n, input int vld_until, input int ack_k, input int done_k);
    for (int k = 0; k < TN; k++) tr[k] = '0;
    for (int k = 1; k <= n; k++) begin
      tick();
      tr[k]       = snap();
      instr_valid = (k < vld_until);
      mem_ack     = (k == ack_k);
      alu_done    = (k == done_k);
    end
    instr_valid = 1'b0;
    mem_ack     = 1'b0;
    alu_done    = 1'b0;
  endtask

  task automatic issue(input logic [15:0] ins);
    for (int i = 0; i < 20 && instr_ready !== 1'b1; i++) tick();
    total++;
    if (instr_ready !== 1'b1) begin
      bad++;
      $display("FAIL ready_wait instr=%h got=%b want=1", ins, instr_ready);
    end
    instr       = ins;
    instr_valid = 1'b1;
  endtask

  function automatic int cnt(input int b, input int lo, input int hi);
    int c = 0;
    for (int k = lo; k <= hi; k++) c += int'(tr[k][b]);
    return c;
  endfunction

  function automatic int first(input int b);
    for (int k = 1; k < TN; k++) if (tr[k][b]) return k;
    return -1;
  endfunction

  task automatic test_reset();
    rst = 1'b0; instr_valid = 1'b0; instr = '0; mem_ack = 1'b0; alu_done = 1'b0;
    tick(); tick();
    total++;
    if (snap() !== 10'b0) begin bad++; $display("FAIL reset_outputs got=%b want=0", snap()); end
    rst = 1'b1;
    #1;
    total++;
    if (instr_ready !== 1'b0) begin bad++; $display("FAIL ready_at_release got=%b want=0", instr_ready); end
    tick();
    total++;
    if (instr_ready !== 1'b1 || busy !== 1'b0) begin
      bad++; $display("FAIL ready_after_release got=%b%b want=10", instr_ready, busy);
    end
  endtask

  task automatic test_nop();
    issue(16'h0000);
    run(3, 1, 0, 0);
    total++;
    if (cnt(B_BUSY, 1, 3) !== 1 || tr[1][B_BUSY] !== 1'b1) begin
      bad++; $display("FAIL nop_busy got=%0d want=1", cnt(B_BUSY, 1, 3));
    end
    total++;
    if (cnt(B_LSE, 1, 3) + cnt(B_LDM, 1, 3) + cnt(B_LACC, 1, 3) !== 0) begin
      bad++; $display("FAIL nop_strobes got=%0d want=0", cnt(B_LSE, 1, 3) + cnt(B_LDM, 1, 3) + cnt(B_LACC, 1, 3));
    end
    total++;
    if (tr[2][B_RDY] !== 1'b1) begin bad++; $display("FAIL nop_ready_t2 got=%b want=1", tr[2][B_RDY]); end
  endtask

  task automatic test_ldi();
    issue(16'h0600);
    run(4, 1, 0, 0);
    total++;
    if (first(B_LSE) !== 2 || cnt(B_LSE, 1, 4) !== 1) begin
      bad++; $display("FAIL ldi_lse first=%0d count=%0d want=2/1", first(B_LSE), cnt(B_LSE, 1, 4));
    end
    total++;
    if (cnt(B_LDM, 1, 4) + cnt(B_LACC, 1, 4) !== 0) begin
      bad++; $display("FAIL ldi_other_strobes got=%0d want=0", cnt(B_LDM, 1, 4) + cnt(B_LACC, 1, 4));
    end
    total++;
    if (tr[2][B_RW] !== 1'b1) begin bad++; $display("FAIL ldi_rw got=%b want=1", tr[2][B_RW]); end
    total++;
    if (tr[3][B_BUSY] !== 1'b0 || tr[3][B_RDY] !== 1'b1) begin
      bad++; $display("FAIL ldi_idle_t3 got busy=%b rdy=%b want 0/1", tr[3][B_BUSY], tr[3][B_RDY]);
    end
  endtask

  task automatic test_ld_wait();
    issue(16'h0800);
    run(9, 1, 5, 0);
    total++;
    if (first(B_REQ) !== 2 || cnt(B_REQ, 1, 9) !== 4) begin
      bad++; $display("FAIL ld_req first=%0d count=%0d want=2/4", first(B_REQ), cnt(B_REQ, 1, 9));
    end
    total++;
    if (cnt(B_WE, 1, 9) !== 0) begin bad++; $display("FAIL ld_we got=%0d want=0", cnt(B_WE, 1, 9)); end
    total++;
    if (first(B_LDM) !== 6 || cnt(B_LDM, 1, 9) !== 1) begin
      bad++; $display("FAIL ld_ldm first=%0d count=%0d want=6/1", first(B_LDM), cnt(B_LDM, 1, 9));
    end
    total++;
    if (cnt(B_RW, 1, 9) !== 0) begin bad++; $display("FAIL ld_rw got=%0d want=0", cnt(B_RW, 1, 9)); end
    total++;
    if (tr[7][B_BUSY] !== 1'b0 || tr[6][B_BUSY] !== 1'b1) begin
      bad++; $display("FAIL ld_latency got t6=%b t7=%b want 1/0", tr[6][B_BUSY], tr[7][B_BUSY]);
    end
  endtask

  task automatic test_st();
    issue(16'h0E00);
    run(6, 1, 3, 0);
    total++;
    if (first(B_RW) !== 2 || first(B_REQ) !== 3) begin
      bad++; $display("FAIL st_rw_before_req rw=%0d req=%0d want=2/3", first(B_RW), first(B_REQ));
    end
    total++;
    if (tr[3][B_WE] !== 1'b1 || cnt(B_REQ, 1, 6) !== 1) begin
      bad++; $display("FAIL st_req_we we=%b req_count=%0d want=1/1", tr[3][B_WE], cnt(B_REQ, 1, 6));
    end
    total++;
    if (cnt(B_LSE, 1, 6) + cnt(B_LDM, 1, 6) + cnt(B_LACC, 1, 6) !== 0) begin
      bad++; $display("FAIL st_strobes got=%0d want=0", cnt(B_LSE, 1, 6) + cnt(B_LDM, 1, 6) + cnt(B_LACC, 1, 6));
    end
    total++;
    if (tr[4][B_BUSY] !== 1'b0 || tr[3][B_BUSY] !== 1'b1) begin
      bad++; $display("FAIL st_latency got t3=%b t4=%b want 1/0", tr[3][B_BUSY], tr[4][B_BUSY]);
    end
  endtask

  task automatic test_alu();
    issue(16'h1200);
    run(6, 1, 2, 3);
    total++;
    if (first(B_AST) !== 2 || cnt(B_AST, 1, 6) !== 1) begin
      bad++; $display("FAIL alu_start first=%0d count=%0d want=2/1", first(B_AST), cnt(B_AST, 1, 6));
    end
    total++;
    if (first(B_LACC) !== 4 || cnt(B_LACC, 1, 6) !== 1 || tr[4][B_RW] !== 1'b1) begin
      bad++; $display("FAIL alu_lacc first=%0d rw=%b want=4/1", first(B_LACC), tr[4][B_RW]);
    end
    total++;
    if (cnt(B_ERR, 1, 6) !== 0 || cnt(B_LDM, 1, 6) !== 0 || tr[5][B_BUSY] !== 1'b0) begin
      bad++; $display("FAIL alu_stray_ack err=%0d ldm=%0d busy5=%b want=0/0/0", cnt(B_ERR, 1, 6), cnt(B_LDM, 1, 6), tr[5][B_BUSY]);
    end
  endtask

  task automatic test_timeout();
    issue(16'h1000);
    run(20, 1, 0, 0);
    total++;
    if (cnt(B_AST, 1, 20) !== 1) begin bad++; $display("FAIL tmo_alu_start got=%0d want=1", cnt(B_AST, 1, 20)); end
    total++;
    if (first(B_ERR) !== 17 || cnt(B_ERR, 1, 20) !== 1) begin
      bad++; $display("FAIL tmo_err first=%0d count=%0d want=17/1", first(B_ERR), cnt(B_ERR, 1, 20));
    end
    total++;
    if (cnt(B_LACC, 1, 20) !== 0) begin bad++; $display("FAIL tmo_lacc got=%0d want=0", cnt(B_LACC, 1, 20)); end
    total++;
    if (tr[16][B_BUSY] !== 1'b1 || tr[17][B_BUSY] !== 1'b0) begin
      bad++; $display("FAIL tmo_busy got t16=%b t17=%b want 1/0", tr[16][B_BUSY], tr[17][B_BUSY]);
    end
  endtask

  task automatic test_ack_at_expiry();
    issue(16'h0800);
    run(20, 1, 16, 0);
    total++;
    if (cnt(B_REQ, 1, 20) !== 15 || cnt(B_ERR, 1, 20) !== 0) begin
      bad++; $display("FAIL expiry_ack req=%0d err=%0d want=15/0", cnt(B_REQ, 1, 20), cnt(B_ERR, 1, 20));
    end
    total++;
    if (first(B_LDM) !== 17 || tr[18][B_BUSY] !== 1'b0) begin
      bad++; $display("FAIL expiry_ldm first=%0d busy18=%b want=17/0", first(B_LDM), tr[18][B_BUSY]);
    end
  endtask

  task automatic test_illegal();
    issue(16'hFC00);
    run(4, 1, 0, 0);
    total++;
    if (first(B_ERR) !== 2 || cnt(B_ERR, 1, 4) !== 1) begin
      bad++; $display("FAIL ill_err first=%0d count=%0d want=2/1", first(B_ERR), cnt(B_ERR, 1, 4));
    end
    total++;
    if (cnt(B_LSE, 1, 4) + cnt(B_LDM, 1, 4) + cnt(B_LACC, 1, 4) + cnt(B_REQ, 1, 4) !== 0) begin
      bad++; $display("FAIL ill_strobes got=%0d want=0", cnt(B_LSE, 1, 4) + cnt(B_LDM, 1, 4) + cnt(B_LACC, 1, 4) + cnt(B_REQ, 1, 4));
    end
    total++;
    if (tr[2][B_BUSY] !== 1'b0 || tr[2][B_RDY] !== 1'b1) begin
      bad++; $display("FAIL ill_idle got busy=%b rdy=%b want 0/1", tr[2][B_BUSY], tr[2][B_RDY]);
    end
  endtask

  task automatic test_back_to_back();
    issue(16'h0400);
    run(7, 5, 0, 0);
    total++;
    if (cnt(B_LSE, 1, 7) !== 2 || tr[2][B_LSE] !== 1'b1 || tr[5][B_LSE] !== 1'b1) begin
      bad++; $display("FAIL b2b_lse count=%0d want=2 at t2,t5", cnt(B_LSE, 1, 7));
    end
    total++;
    if (tr[3][B_RDY] !== 1'b1 || tr[4][B_BUSY] !== 1'b1 || tr[6][B_BUSY] !== 1'b0) begin
      bad++; $display("FAIL b2b_handoff got rdy3=%b busy4=%b busy6=%b want 1/1/0", tr[3][B_RDY], tr[4][B_BUSY], tr[6][B_BUSY]);
    end
  endtask

  task automatic test_reset_mid_ld();
    issue(16'h0A00);
    run(3, 1, 0, 0);
    total++;
    if (tr[3][B_REQ] !== 1'b1 || tr[3][B_RW] !== 1'b1) begin
      bad++; $display("FAIL midrst_pre req=%b rw=%b want 1/1", tr[3][B_REQ], tr[3][B_RW]);
    end
    rst = 1'b0;
    #1;
    total++;
    if (mem_req !== 1'b0 || busy !== 1'b0 || rw !== 1'b0) begin
      bad++; $display("FAIL midrst_async req=%b busy=%b rw=%b want 0/0/0", mem_req, busy, rw);
    end
    tick();
    rst = 1'b1;
    run(5, 1, 1, 0);
    total++;
    if (cnt(B_LDM, 1, 5) + cnt(B_REQ, 1, 5) + cnt(B_BUSY, 1, 5) + cnt(B_ERR, 1, 5) !== 0) begin
      bad++; $display("FAIL midrst_late_ack got=%0d want=0", cnt(B_LDM, 1, 5) + cnt(B_REQ, 1, 5) + cnt(B_BUSY, 1, 5) + cnt(B_ERR, 1, 5));
    end
  endtask

  initial begin
    test_reset();
    test_nop();
    test_ldi();
    test_ld_wait();
    test_st();
    test_alu();
    test_timeout();
    test_ack_at_expiry();
    test_illegal();
    test_back_to_back();
    test_reset_mid_ld();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
